rsp_compactor_i11593: RTL and testbench

Downstream response-compaction stage for the I11593 benchmark subcircuit. It consumes the subcircuit's single-bit registered output (plus optional extra response lanes) for a programmed number of valid beats and folds them into a multiple-input signature register (MISR). It then compares the final signature against a golden value and reports pass/fail, so the trojan-detection bench can screen each subcircuit without logging every cycle.

---
 rtl/rsp_compactor_i11593.sv | 141 ++++++++++++++
 tb/tb_rsp_compactor_i11593.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsp_compactor_i11593.sv
// ----------------------------------------------------------------------------
// rsp_compactor_i11593
//
// Response-compaction stage for the I11593 subcircuit. It folds a programmed
// number of valid response beats into a MISR. It then compares the final
// signature against a latched golden value and reports pass/fail.
//
// Optional feature macro: RSP_XMASK_EN
//   When defined, the din_xmask input is added. Masked lanes contribute 0 to
//   the signature, but masked beats still count toward vec_count.
//
// Ports:
//   I1470_clk   in   1      clock; all state updates on the rising edge
//   I1477_rst   in   1      synchronous active-high reset
//   start       in   1      begin a run; sampled only in IDLE or DONE
//   vec_count   in   16     number of beats to compact; sampled with start
//   golden      in   WIDTH  expected signature; sampled with start
//   din_valid   in   1      din holds a beat to compact this cycle
//   din         in   LANES  response bits; bit 0 is the I11593 output
//   din_xmask   in   LANES  per-lane don't-care mask (RSP_XMASK_EN only)
//   busy        out  1      high while in RUN
//   done        out  1      high while in DONE
//   pass        out  1      signature == latched golden; valid while done=1
//   signature   out  WIDTH  current MISR contents
//   beats_left  out  16     beats remaining in the current run
// ----------------------------------------------------------------------------
module rsp_compactor_i11593 #(
    parameter int unsigned      WIDTH = 16,
    parameter int unsigned      LANES = 1,
    parameter logic [WIDTH-1:0] POLY  = 16'h1021,
    parameter logic [WIDTH-1:0] SEED  = 16'h0000
) (
    input  logic             I1470_clk,
    input  logic             I1477_rst,
    input  logic             start,
    input  logic [15:0]      vec_count,
    input  logic [WIDTH-1:0] golden,
    input  logic             din_valid,
    input  logic [LANES-1:0] din,
`ifdef RSP_XMASK_EN
    input  logic [LANES-1:0] din_xmask,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [15:0]      beats_left
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [WIDTH-1:0] golden_q, golden_d;
    logic [15:0]      beats_q, beats_d;
    logic             pass_q, pass_d;

    logic [LANES-1:0] din_eff;
    logic [WIDTH-1:0] misr_next;

    // Lanes flagged as don't-care are forced to 0 before they reach the MISR.
`ifdef RSP_XMASK_EN
    assign din_eff = din & ~din_xmask;
`else
    assign din_eff = din;
`endif

    // Galois-style MISR step: shift left, then fold in the taps when the MSB
    // leaves, then XOR the response lanes into the low bits.
    always_comb begin
        misr_next = {sig_q[WIDTH-2:0], 1'b0};
        if (sig_q[WIDTH-1]) begin
            misr_next = misr_next ^ POLY;
        end
        misr_next = misr_next ^ WIDTH'(din_eff);
    end

    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        golden_d = golden_q;
        beats_d  = beats_q;
        pass_d   = pass_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    sig_d    = SEED;
                    golden_d = golden;
                    beats_d  = vec_count;
                    if (vec_count != 16'd0) begin
                        state_d = StRun;
                        pass_d  = 1'b0;
                    end else begin
                        // Empty run: the verdict is the seed itself.
                        state_d = StDone;
                        pass_d  = (SEED == golden);
                    end
                end
            end
            StRun: begin
                if (din_valid) begin
                    sig_d = misr_next;
                    if (beats_q != 16'd0) begin
                        beats_d = beats_q - 16'd1;
                    end
                    if (beats_q <= 16'd1) begin
                        state_d = StDone;
                        pass_d  = (misr_next == golden_q);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            state_q  <= StIdle;
            sig_q    <= SEED;
            golden_q <= '0;
            beats_q  <= 16'd0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            golden_q <= golden_d;
            beats_q  <= beats_d;
            pass_q   <= pass_d;
        end
    end

    assign busy       = (state_q == StRun);
    assign done       = (state_q == StDone);
    assign pass       = pass_q;
    assign signature  = sig_q;
    assign beats_left = beats_q;

endmodule

// File: tb/tb_rsp_compactor_i11593.sv
module tb_rsp_compactor_i11593;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] vec_count = '0;
    logic [15:0] golden = '0;
    logic        din_valid = 1'b0;
    logic [0:0]  din = '0;
    logic        busy, done, pass;
    logic [15:0] signature, beats_left;

    // Second instance with two lanes for the masking scenario.
    logic        start2 = 1'b0;
    logic [15:0] vec_count2 = '0;
    logic [15:0] golden2 = '0;
    logic        din_valid2 = 1'b0;
    logic [1:0]  din2 = '0;
    logic        busy2, done2, pass2;
    logic [15:0] signature2, beats_left2;
`ifdef RSP_XMASK_EN
    logic [0:0]  din_xmask = '0;
    logic [1:0]  din_xmask2 = '0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rsp_compactor_i11593 u_dut (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .start     (start),
        .vec_count (vec_count),
        .golden    (golden),
        .din_valid (din_valid),
        .din       (din),
`ifdef RSP_XMASK_EN
        .din_xmask (din_xmask),
`endif
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature),
        .beats_left(beats_left)
    );

    rsp_compactor_i11593 #(.LANES(2)) u_dut2 (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .start     (start2),
        .vec_count (vec_count2),
        .golden    (golden2),
        .din_valid (din_valid2),
        .din       (din2),
`ifdef RSP_XMASK_EN
        .din_xmask (din_xmask2),
`endif
        .busy      (busy2),
        .done      (done2),
        .pass      (pass2),
        .signature (signature2),
        .beats_left(beats_left2)
    );

    typedef struct {
        logic        st;
        logic [15:0] vc;
        logic [15:0] g;
        logic        dv;
        logic        d;
        logic        e_busy;
        logic        e_done;
        logic        e_pass;
        logic [15:0] e_sig;
        logic [15:0] e_beats;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic [15:0] vc, logic [15:0] g, logic dv, logic d,
                                logic eb, logic ed, logic ep, logic [15:0] es,
                                logic [15:0] ebl);
        vec_t v;
        v.st = st; v.vc = vc; v.g = g; v.dv = dv; v.d = d;
        v.e_busy = eb; v.e_done = ed; v.e_pass = ep; v.e_sig = es; v.e_beats = ebl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic eb, input logic ed,
                             input logic [15:0] es, input logic [15:0] ebl);
        chk({name, ".busy"}, 32'(busy), 32'(eb));
        chk({name, ".done"}, 32'(done), 32'(ed));
        chk({name, ".signature"}, 32'(signature), 32'(es));
        chk({name, ".beats_left"}, 32'(beats_left), 32'(ebl));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [15:0] vc, input logic [15:0] g,
                         input logic dv, input logic d);
        start = st; vec_count = vc; golden = g; din_valid = dv; din = d;
    endtask

    initial begin
        // Test 1: single beat.
        vecs.push_back(mk(1, 16'd1, 16'h0001, 0, 0, 1, 0, 0, 16'h0000, 16'd1));
        vecs.push_back(mk(0, 16'd0, 16'h0000, 1, 1, 0, 1, 1, 16'h0001, 16'd0));
        // din_valid in DONE is ignored.
        vecs.push_back(mk(0, 16'd0, 16'h0000, 1, 1, 0, 1, 1, 16'h0001, 16'd0));
        // Test 2: 17 ones; MSB first set on beat 16, feedback on beat 17.
        for (int pass_no = 0; pass_no < 2; pass_no++) begin
            vecs.push_back(mk(1, 16'd17, (pass_no == 0) ? 16'hEFDE : 16'hEFDF, 0, 0,
                              1, 0, 0, 16'h0000, 16'd17));
            for (int k = 1; k <= 16; k++) begin
                vecs.push_back(mk(0, 16'd0, 16'h0000, 1, 1, 1, 0, 0,
                                  16'((32'd1 << k) - 32'd1), 16'(17 - k)));
            end
            vecs.push_back(mk(0, 16'd0, 16'h0000, 1, 1, 0, 1, (pass_no == 0) ? 1'b1 : 1'b0,
                              16'hEFDE, 16'd0));
        end
        // Test 4: empty runs, matching and mismatching golden.
        vecs.push_back(mk(1, 16'd0, 16'h0000, 0, 0, 0, 1, 1, 16'h0000, 16'd0));
        vecs.push_back(mk(1, 16'd0, 16'h1234, 0, 0, 0, 1, 0, 16'h0000, 16'd0));

        // Reset state.
        drive(0, 0, 0, 0, 0);
        step();
        step();
        chk_state("reset", 0, 0, 16'h0000, 16'd0);
        chk("reset.pass", 32'(pass), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].vc, vecs[i].g, vecs[i].dv, vecs[i].d);
            step();
            chk_state($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_done,
                      vecs[i].e_sig, vecs[i].e_beats);
            if (vecs[i].e_done) chk($sformatf("vec%0d.pass", i), 32'(pass), 32'(vecs[i].e_pass));
        end

        // Test 3: gap between beats.
        drive(1, 16'd2, 16'h0003, 0, 0);
        step();
        drive(0, 0, 0, 1, 1);
        step();
        chk_state("gap.beat1", 1, 0, 16'h0001, 16'd1);
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_state($sformatf("gap.hold%0d", i), 1, 0, 16'h0001, 16'd1);
        end
        drive(0, 0, 0, 1, 1);
        step();
        chk_state("gap.beat2", 0, 1, 16'h0003, 16'd0);
        chk("gap.pass", 32'(pass), 32'd1);

        // Test 4b: start mid-run is ignored.
        drive(1, 16'd4, 16'h0000, 0, 0);
        step();
        drive(0, 0, 0, 1, 0);
        step();
        step();
        chk_state("midstart.pre", 1, 0, 16'h0000, 16'd2);
        drive(1, 16'd4, 16'hFFFF, 0, 0);
        step();
        chk_state("midstart.ignored", 1, 0, 16'h0000, 16'd2);
        drive(0, 0, 0, 1, 0);
        step();
        chk_state("midstart.b3", 1, 0, 16'h0000, 16'd1);
        step();
        chk_state("midstart.b4", 0, 1, 16'h0000, 16'd0);
        chk("midstart.pass", 32'(pass), 32'd1);

        // Test 5: reset after 3 of 8 beats; reset beats start and din_valid.
        drive(1, 16'd8, 16'h0000, 0, 0);
        step();
        drive(0, 0, 0, 1, 1);
        step();
        step();
        step();
        chk_state("rstmid.pre", 1, 0, 16'h0007, 16'd5);
        rst = 1'b1;
        drive(1, 16'd8, 16'h0000, 1, 1);
        step();
        chk_state("rstmid.after", 0, 0, 16'h0000, 16'd0);
        chk("rstmid.pass", 32'(pass), 32'd0);
        rst = 1'b0;
        drive(1, 16'd1, 16'h0001, 0, 0);
        step();
        drive(0, 0, 0, 1, 1);
        step();
        chk_state("rstmid.fresh", 0, 1, 16'h0001, 16'd0);
        chk("rstmid.fresh_pass", 32'(pass), 32'd1);
        drive(0, 0, 0, 0, 0);

        // Test 6: two lanes, din=2'b11, upper lane masked when masking exists.
        start2 = 1'b1; vec_count2 = 16'd1; golden2 = 16'h0000;
        step();
        start2 = 1'b0; din_valid2 = 1'b1; din2 = 2'b11;
`ifdef RSP_XMASK_EN
        din_xmask2 = 2'b10;
`endif
        step();
        din_valid2 = 1'b0;
        chk("lanes.done", 32'(done2), 32'd1);
`ifdef RSP_XMASK_EN
        chk("lanes.signature", 32'(signature2), 32'h0001);
`else
        chk("lanes.signature", 32'(signature2), 32'h0003);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
